ex_muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide execution unit beside the single-cycle integer EX stage. ID issues MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU here via valid/ready; the unit holds one operation in flight and returns rd address plus result for the EX/MEM path. Datapath width and multiplier latency are parametrised; the divider is a restoring radix-2 iterator with single-cycle special-case exits.

---
 rtl/ex_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: one op in flight, valid/ready issue and response.
// Optional restoring divider compiled in with `define EX_MULDIV_DIV_EN.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [4:0]      rd_in,
  output logic            resp_valid_out,
  input  logic            resp_ready_in,
  output logic [4:0]      resp_rd_out,
  output logic [XLEN-1:0] resp_data_out,
  output logic            busy_out,
  output logic [1:0]      dbg_state_out
);

  // Handshake: a request transfers on a rising edge where req_valid_in,
  // req_ready_out and rdy_in are high and flush_in is low; a response
  // transfers where resp_valid_out, resp_ready_in and rdy_in are high.
  // resp_valid_out/resp_rd_out/resp_data_out stay stable until that edge.

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int CW = $clog2(XLEN + MUL_STAGES + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;

  // Operands extended to the full product width so one unsigned multiply
  // covers signed, unsigned and mixed-sign variants.
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_w, b_w, prod;

  always_comb begin
    a_sgn = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
    b_sgn = (op_q[1:0] == 2'b01);
    a_w   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    b_w   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    prod  = a_w * b_w;
  end

`ifdef EX_MULDIV_DIV_EN
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            div_sgn, a_neg, b_neg, in_neg;
  logic [XLEN-1:0] b_mag, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] most_neg;

  always_comb begin
    most_neg = {1'b1, {(XLEN-1){1'b0}}};
    div_sgn  = ~op_q[0];
    a_neg    = div_sgn & a_q[XLEN-1];
    b_neg    = div_sgn & b_q[XLEN-1];
    in_neg   = ~op_in[0] & rs1_in[XLEN-1];
    b_mag    = b_neg ? -b_q : b_q;
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, b_mag};
    q_fix    = (a_neg ^ b_neg) ? -quo_q : quo_q;
    r_fix    = a_neg ? -rem_q : rem_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    res_d   = res_q;
`ifdef EX_MULDIV_DIV_EN
    quo_d   = quo_q;
    rem_d   = rem_q;
`endif
    if (flush_in) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_in) begin
            op_d = op_in;
            a_d  = rs1_in;
            b_d  = rs2_in;
            rd_d = rd_in;
            if (op_in[2]) begin
              state_d = S_DIV;
              cnt_d   = '0;
`ifdef EX_MULDIV_DIV_EN
              quo_d   = in_neg ? -rs1_in : rs1_in;
              rem_d   = '0;
`endif
            end else begin
              state_d = S_MUL;
              cnt_d   = CW'(MUL_STAGES - 1);
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
            res_d   = (op_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DIV: begin
`ifdef EX_MULDIV_DIV_EN
          if (cnt_q == '0 && b_q == '0) begin
            state_d = S_DONE;
            res_d   = op_q[1] ? a_q : '1;
          end else if (cnt_q == '0 && div_sgn && a_q == most_neg && b_q == '1) begin
            state_d = S_DONE;
            res_d   = op_q[1] ? '0 : a_q;
          end else if (cnt_q == CW'(XLEN)) begin
            // Fix-up cycle: restore signs on the magnitude results.
            state_d = S_DONE;
            cnt_d   = '0;
            res_d   = op_q[1] ? r_fix : q_fix;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (!diff[XLEN]) begin
              rem_d = diff[XLEN-1:0];
              quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_d = rem_sh[XLEN-1:0];
              quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
          end
`else
          state_d = S_DONE;
          res_d   = '1;
`endif
        end
        S_DONE: begin
          if (resp_ready_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

`ifdef EX_MULDIV_DIV_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end
`endif

  assign req_ready_out  = rst_n_in & (state_q == S_IDLE);
  assign resp_valid_out = (state_q == S_DONE);
  assign resp_rd_out    = rd_q;
  assign resp_data_out  = res_q;
  assign busy_out       = (state_q != S_IDLE);
  assign dbg_state_out  = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M vectors, randomized ops
// against an arithmetic reference model, stalls, flush and async reset.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam int MS   = 2;
`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, rdy, flush, req_valid, req_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic [4:0]      rd;
  logic            resp_valid, resp_ready;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_data;
  logic            busy;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .op_in(op),
    .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_rd_out(resp_rd), .resp_data_out(resp_data),
    .busy_out(busy), .dbg_state_out(dbg_state)
  );

  // Reference result from RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (!DIV_EN) return 32'hFFFF_FFFF;
        if (b == 32'd0) begin
          q = -1; r = sa;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = sa; r = 0;
        end else if (!f[0]) begin
          q = sa / sb; r = sa % sb;
        end else begin
          q = ua / ub; r = ua % ub;
        end
        p = f[1] ? r : q;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MS;
    if (!DIV_EN) return 1;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Caller is positioned at a negedge; returns at the negedge after consumption.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] exp_data, input int exp_lat,
                       input bit stall_en, input int hold_n);
    int lat, stalls;
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; op = f; rs1 = a; rs2 = b; rd = r; rdy = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL busy_after_issue: busy=%b req_ready=%b want 1/0", busy, req_ready);
    end
    lat = 0; stalls = 0;
    while (resp_valid !== 1'b1 && lat < 300) begin
      rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rdy) stalls++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    rdy = 1'b1;
    checks++;
    if (lat != exp_lat + stalls) begin
      errors++; $display("FAIL latency op=%0d a=%h b=%h: got %0d want %0d", f, a, b, lat, exp_lat + stalls);
    end
    checks++;
    if (resp_data !== exp_data || resp_rd !== r) begin
      errors++; $display("FAIL result op=%0d a=%h b=%h: got %h rd=%0d want %h rd=%0d", f, a, b, resp_data, resp_rd, exp_data, r);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_done: got %b want 0", req_ready);
    end
    held_data = exp_data; held_rd = r;
    for (int k = 0; k < hold_n; k++) begin
      rdy = 1'($urandom_range(0, 1));
      resp_ready = rdy ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== held_data || resp_rd !== held_rd) begin
        errors++; $display("FAIL hold_stable: valid=%b data=%h rd=%0d want 1 %h %0d", resp_valid, resp_data, resp_rd, held_data, held_rd);
      end
    end
    rdy = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL consume: valid=%b req_ready=%b busy=%b want 0/1/0", resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; req_valid = 1'b0; op = '0;
    rs1 = '0; rs2 = '0; rd = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_rd !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ready=%b valid=%b data=%h rd=%0d busy=%b want all 0",
                         req_ready, resp_valid, resp_data, resp_rd, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, resp_valid);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [13];
    logic [31:0] t_a [13], t_b [13], t_e [13];
    t_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd5};
    t_a  = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
             32'h8000_0000, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
    t_b  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'd3,
             32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    t_e  = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFFA,
             32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd3};
    for (int i = 0; i < 13; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], (i == 4) ? 5'd0 : 5'(i + 1),
            (t_op[i][2] && !DIV_EN) ? 32'hFFFF_FFFF : t_e[i],
            model_lat(t_op[i], t_a[i], t_b[i]), 1'b0, 0);
    end
  endtask

  task automatic test_stall();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, MS, 1'b0, 5);
    do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, model(3'd4, 32'hFFFF_FFEC, 32'd3),
          model_lat(3'd4, 32'hFFFF_FFEC, 32'd3), 1'b1, 3);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      do_op(f, a, b, 5'($urandom), model(f, a, b), model_lat(f, a, b), 1'b1, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      do_op(f, a, b, 5'(i), model(f, a, b), model_lat(f, a, b), 1'b0, 0);
    end
  endtask

  task automatic test_flush();
    int  delay, n;
    bit  seen;
    delay = DIV_EN ? 10 : 0;
    req_valid = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd = 5'd3; rdy = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1; rdy = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; rdy = 1'b1; req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_div: busy=%b valid=%b ready=%b want 0/0/1", busy, resp_valid, req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_quiet: got activity=1 want 0");
    end
    // Flush of a held result.
    req_valid = 1'b1; op = 3'd0; rs1 = 32'd6; rs2 = 32'd7; rd = 5'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'd42) begin
      errors++; $display("FAIL flush_pre_result: valid=%b data=%h want 1 0000002a", resp_valid, resp_data);
    end
    flush = 1'b1; rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; rdy = 1'b1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done: valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
    // Request presented together with flush in IDLE is dropped.
    flush = 1'b1; req_valid = 1'b1; op = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1 || resp_valid === 1'b1) seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_drop_req: got activity=1 want 0");
    end
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1; op = 3'd4; rs1 = 32'd12345; rs2 = 32'd11; rd = 5'd21;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== '0 || resp_rd !== '0) begin
      errors++; $display("FAIL async_reset: ready=%b valid=%b busy=%b data=%h rd=%0d want all 0",
                         req_ready, resp_valid, busy, resp_data, resp_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_release: ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, resp_valid);
    end
    do_op(3'd0, 32'd3, 32'd3, 5'd1, 32'd9, MS, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
